stack_sequencer: RTL and testbench
==================================

# stack_sequencer

Fetch/decode/execute controller sitting directly upstream of the CPU operand stack. Fetches 18-bit instructions from a synchronous instruction ROM and executes them against a 14-bit working register R. Drives the stack's opcode, push-data and reset inputs and captures its pop output. Tracks stack depth so overflow and underflow are trapped before the stack is touched.

## Interface
- DATA_W, 14, width of R and of stack data
- ADDR_W, 8, program counter / instruction ROM address width
- DEPTH, 12, stack capacity in entries; must equal the stack's VOLUME
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- run  in  1  sampled in IDLE; high starts execution at pc=0
- imem_addr  out  ADDR_W  instruction ROM address (= pc)
- imem_data  in  DATA_W+4  instruction word, valid one cycle after imem_addr
- stk_opcode  out  4  stack opcode; OP_NOP unless issuing PUSH/POP
- stk_push  out  DATA_W  data to push (= R)
- stk_pop  in  DATA_W  stack pop data, valid the cycle after a POP issue
- stk_reset  out  1  active-high synchronous reset for the stack
- r_out  out  DATA_W  current R
- depth  out  $clog2(DEPTH+1)  current stack occupancy
- halted  out  1  high in HALT or ERROR
- err  out  2  0 none, 1 overflow, 2 underflow, 3 illegal opcode

## Operation
- Instruction word: [DATA_W+3:DATA_W] opcode, [DATA_W-1:0] immediate imm.
- Opcodes: NOP 0x0, LOAD_I 0x1 (R<=imm), PUSH_R 0x2, POP_R 0x3, ADD_I 0x4 (R<=R+imm mod 2^DATA_W, carry dropped), JMP 0x5 (pc<=imm[ADDR_W-1:0]), JZ 0x6 (jump if R==0 else fall through), HALT 0xF; all others illegal.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT, ERROR.
- IDLE -> FETCH when run=1. FETCH: imem_addr=pc. DECODE: latch imem_data into ir. EXEC: perform op; non-jump ops pc<=pc+1 (wraps 2^ADDR_W-1 -> 0). Next state FETCH, except POP_R -> WB, HALT -> HALT, fault -> ERROR.
- PUSH_R: if depth==DEPTH, err<=1, ERROR, stk_opcode stays OP_NOP. Else stk_opcode=OP_PUSH_R, stk_push=R for exactly the EXEC cycle; depth+1.
- POP_R: if depth==0, err<=2, ERROR, no stack op. Else stk_opcode=OP_POP_R for the EXEC cycle; depth-1; WB: R<=stk_pop.
- Illegal opcode: err<=3, ERROR; pc, R, depth unchanged.
- HALT/ERROR: halted=1, all outputs frozen, stk_opcode=OP_NOP; exit only by reset. run ignored outside IDLE.
- stk_opcode is registered and returns to OP_NOP between stack operations (always ≥2 NOP cycles between issues), so each PUSH/POP is a distinct one-cycle pulse.

## Timing
- Reset values: state IDLE, pc=0, R=0, ir=0, depth=0, stk_opcode=OP_NOP, stk_push=0, halted=0, err=0, stk_reset=1.
- stk_reset held 1 while reset low and for the first clk edge after release, then 0; guarantees stack pointer cleared consistent with depth=0.
- Latency: NOP/LOAD_I/ADD_I/PUSH_R/JMP/JZ 3 cycles (FETCH, DECODE, EXEC); POP_R 4 cycles (+WB).
- run sampled on the edge leaving IDLE; first FETCH is the following cycle.
- Reset asserted mid-instruction: abort immediately, no partial R/pc/depth update; a PUSH/POP pulse in flight is dropped.

## Structure
- Opcode constants (shared with the stack, OP_NOP/OP_PUSH_R/OP_POP_R values identical) and err codes belong in the shared opcodes include.
- State encodings local localparams.
- Single module; no sub-module needed. Optionally split the ALU (LOAD/ADD/JZ test) into alu_lite.

## Test plan
- Reset then run=1, program LOAD_I 5; PUSH_R; LOAD_I 9; POP_R; HALT -> stk_opcode=0x2 with stk_push=5 in cycle 6, 0x3 in cycle 12, R=5 after WB, depth 0, halted=1, err=0.
- 13 consecutive PUSH_R with DEPTH=12 -> 12 push pulses, depth=12, 13th: no pulse, err=1, halted=1.
- POP_R first instruction -> no stack pulse, err=2, depth=0, pc=0.
- LOAD_I 0x3FFF; ADD_I 2; JZ 0x20 -> R=1, no jump (pc advances to 3); LOAD_I 0; JZ 0x20 -> pc=0x20.
- Opcode 0x9 -> err=3, halted=1; pc=0xFF NOP -> pc wraps to 0.
- Reset low during POP EXEC -> all outputs at reset values asynchronously, stk_reset=1 for one edge after release.

Source files
------------

// File: rtl/stack_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stack_sequencer_pkg                                                  |
// | Opcode and error-code constants shared with the operand stack.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package stack_sequencer_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_LOAD_I = 4'h1;
  localparam logic [3:0] OP_PUSH_R = 4'h2;
  localparam logic [3:0] OP_POP_R  = 4'h3;
  localparam logic [3:0] OP_ADD_I  = 4'h4;
  localparam logic [3:0] OP_JMP    = 4'h5;
  localparam logic [3:0] OP_JZ     = 4'h6;
  localparam logic [3:0] OP_HALT   = 4'hF;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/stack_sequencer_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stack_sequencer_alu                                                  |
// | Next-R computation for LOAD_I/ADD_I and the zero test used by JZ.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module stack_sequencer_alu
  import stack_sequencer_pkg::*;
#(
  parameter int DATA_W = 14
) (
  input  logic [3:0]        i_op,
  input  logic [DATA_W-1:0] i_r,
  input  logic [DATA_W-1:0] i_imm,
  output logic [DATA_W-1:0] o_r_next,
  output logic              o_zero
);

  always_comb begin
    o_r_next = i_r;
    case (i_op)
      OP_LOAD_I: o_r_next = i_imm;
      // Carry out of the top bit is intentionally discarded.
      OP_ADD_I:  o_r_next = i_r + i_imm;
      default:   o_r_next = i_r;
    endcase
  end

  assign o_zero = (i_r == '0);

endmodule
`default_nettype wire

// File: rtl/stack_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stack_sequencer                                                      |
// | Fetch/decode/execute controller driving the CPU operand stack.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module stack_sequencer
  import stack_sequencer_pkg::*;
#(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_run,
  output logic [ADDR_W-1:0]            o_imem_addr,
  input  logic [DATA_W+3:0]            i_imem_data,
  output logic [3:0]                   o_stk_opcode,
  output logic [DATA_W-1:0]            o_stk_push,
  input  logic [DATA_W-1:0]            i_stk_pop,
  output logic                         o_stk_reset,
  output logic [DATA_W-1:0]            o_r_out,
  output logic [$clog2(DEPTH+1)-1:0]   o_depth,
  output logic                         o_halted,
  output logic [1:0]                   o_err
);

  localparam int DEPTH_W = $clog2(DEPTH+1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_r;
  logic [DATA_W+3:0]   r_ir;
  logic [DEPTH_W-1:0]  r_depth;
  logic [3:0]          r_stk_opcode;
  logic [DATA_W-1:0]   r_stk_push;
  logic                r_halted;
  logic [1:0]          r_err;
  logic                r_stk_reset;

  logic [3:0]          w_dec_op;
  logic [3:0]          w_ir_op;
  logic [DATA_W-1:0]   w_ir_imm;
  logic [DATA_W-1:0]   w_alu_r;
  logic                w_r_zero;
  logic                w_full;
  logic                w_empty;

  assign w_dec_op = i_imem_data[DATA_W+3:DATA_W];
  assign w_ir_op  = r_ir[DATA_W+3:DATA_W];
  assign w_ir_imm = r_ir[DATA_W-1:0];
  assign w_full   = (r_depth == DEPTH_W'(DEPTH));
  assign w_empty  = (r_depth == '0);

  stack_sequencer_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_op     (w_ir_op),
    .i_r      (r_r),
    .i_imm    (w_ir_imm),
    .o_r_next (w_alu_r),
    .o_zero   (w_r_zero)
  );

  // Stack reset covers the whole reset window plus the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stk_reset <= 1'b1;
    else        r_stk_reset <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_r          <= '0;
      r_ir         <= '0;
      r_depth      <= '0;
      r_stk_opcode <= OP_NOP;
      r_stk_push   <= '0;
      r_halted     <= 1'b0;
      r_err        <= ERR_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_run) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_ir    <= i_imem_data;
          r_state <= S_EXEC;
          // Stack pulse is decided a cycle early so it lines up with EXEC.
          if (w_dec_op == OP_PUSH_R && !w_full) begin
            r_stk_opcode <= OP_PUSH_R;
            r_stk_push   <= r_r;
          end else if (w_dec_op == OP_POP_R && !w_empty) begin
            r_stk_opcode <= OP_POP_R;
          end
        end
        S_EXEC: begin
          r_stk_opcode <= OP_NOP;
          r_stk_push   <= '0;
          case (w_ir_op)
            OP_NOP: begin
              r_pc    <= r_pc + 1'b1;
              r_state <= S_FETCH;
            end
            OP_LOAD_I, OP_ADD_I: begin
              r_r     <= w_alu_r;
              r_pc    <= r_pc + 1'b1;
              r_state <= S_FETCH;
            end
            OP_PUSH_R: begin
              if (w_full) begin
                r_err    <= ERR_OVERFLOW;
                r_halted <= 1'b1;
                r_state  <= S_ERROR;
              end else begin
                r_depth <= r_depth + 1'b1;
                r_pc    <= r_pc + 1'b1;
                r_state <= S_FETCH;
              end
            end
            OP_POP_R: begin
              if (w_empty) begin
                r_err    <= ERR_UNDERFLOW;
                r_halted <= 1'b1;
                r_state  <= S_ERROR;
              end else begin
                r_depth <= r_depth - 1'b1;
                r_pc    <= r_pc + 1'b1;
                r_state <= S_WB;
              end
            end
            OP_JMP: begin
              r_pc    <= w_ir_imm[ADDR_W-1:0];
              r_state <= S_FETCH;
            end
            OP_JZ: begin
              r_pc    <= w_r_zero ? w_ir_imm[ADDR_W-1:0] : r_pc + 1'b1;
              r_state <= S_FETCH;
            end
            OP_HALT: begin
              r_pc     <= r_pc + 1'b1;
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end
            default: begin
              r_err    <= ERR_ILLEGAL;
              r_halted <= 1'b1;
              r_state  <= S_ERROR;
            end
          endcase
        end
        S_WB: begin
          r_r     <= i_stk_pop;
          r_state <= S_FETCH;
        end
        S_HALT, S_ERROR: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_imem_addr  = r_pc;
  assign o_stk_opcode = r_stk_opcode;
  assign o_stk_push   = r_stk_push;
  assign o_stk_reset  = r_stk_reset;
  assign o_r_out      = r_r;
  assign o_depth      = r_depth;
  assign o_halted     = r_halted;
  assign o_err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_stack_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_stack_sequencer                                                   |
// | Directed and random programs checked against an ISA-level model.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_stack_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  imem_addr;
  logic [17:0] imem_data = '0;
  logic [3:0]  stk_opcode;
  logic [13:0] stk_push;
  logic [13:0] stk_pop = '0;
  logic        stk_reset;
  logic [13:0] r_out;
  logic [3:0]  depth;
  logic        halted;
  logic [1:0]  err;

  always #5 clk = ~clk;

  stack_sequencer #(
    .DATA_W (14),
    .ADDR_W (8),
    .DEPTH  (12)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_run        (run),
    .o_imem_addr  (imem_addr),
    .i_imem_data  (imem_data),
    .o_stk_opcode (stk_opcode),
    .o_stk_push   (stk_push),
    .i_stk_pop    (stk_pop),
    .o_stk_reset  (stk_reset),
    .o_r_out      (r_out),
    .o_depth      (depth),
    .o_halted     (halted),
    .o_err        (err)
  );

  // Synchronous instruction ROM and a behavioural operand stack.
  logic [17:0] rom [256];
  int          smem [16];
  int          sp = 0;

  always @(posedge clk) imem_data <= rom[imem_addr];

  always @(posedge clk) begin
    if (stk_reset) begin
      sp <= 0;
    end else if (stk_opcode == 4'h2) begin
      smem[sp & 15] <= int'(stk_push);
      sp <= sp + 1;
    end else if (stk_opcode == 4'h3) begin
      stk_pop <= 14'(smem[(sp - 1) & 15]);
      sp <= sp - 1;
    end
  end

  typedef struct {int cyc; int op; int data;} ev_t;
  ev_t got_q[$];
  ev_t exp_q[$];
  int  cyc_free = 0;

  always @(negedge clk) begin
    cyc_free++;
    if (stk_opcode != 4'h0)
      got_q.push_back('{cyc_free, int'(stk_opcode), (stk_opcode == 4'h2) ? int'(stk_push) : 0});
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] ins(input int op, input int imm);
    return {op[3:0], imm[13:0]};
  endfunction

  task automatic clear_rom();
    for (int a = 0; a < 256; a++) rom[a] = ins(15, 0);
  endtask

  // ISA-level interpreter: expected architectural state and stack pulses.
  int m_pc, m_r, m_depth, m_err, m_halted;

  task automatic model_run();
    int stk[$];
    int cyc;
    int op, imm;
    m_pc = 0; m_r = 0; m_depth = 0; m_err = 0; m_halted = 0;
    cyc = 1;
    exp_q.delete();
    for (int step = 0; step < 400 && m_halted == 0; step++) begin
      op  = int'(rom[m_pc][17:14]);
      imm = int'(rom[m_pc][13:0]);
      case (op)
        0: m_pc = m_pc + 1;
        1: begin m_r = imm; m_pc = m_pc + 1; end
        2: begin
          if (m_depth == 12) begin m_err = 1; m_halted = 1; end
          else begin
            exp_q.push_back('{cyc + 2, 2, m_r});
            stk.push_back(m_r);
            m_depth++; m_pc = m_pc + 1;
          end
        end
        3: begin
          if (m_depth == 0) begin m_err = 2; m_halted = 1; end
          else begin
            exp_q.push_back('{cyc + 2, 3, 0});
            m_r = stk.pop_back();
            m_depth--; m_pc = m_pc + 1; cyc += 1;
          end
        end
        4: begin m_r = (m_r + imm) % 16384; m_pc = m_pc + 1; end
        5: m_pc = imm % 256;
        6: m_pc = (m_r == 0) ? imm % 256 : m_pc + 1;
        15: m_halted = 1;
        default: begin m_err = 3; m_halted = 1; end
      endcase
      m_pc = m_pc % 256;
      cyc += 3;
    end
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_r", r_out, 0);
    check_eq("rst_depth", depth, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_opcode", stk_opcode, 0);
    check_eq("rst_push", stk_push, 0);
    check_eq("rst_pc", imem_addr, 0);
    check_eq("rst_stk_reset", stk_reset, 1);
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rel_stk_reset_hold", stk_reset, 1);
    @(posedge clk);
    #1;
    check_eq("rel_stk_reset_drop", stk_reset, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    assert_reset();
    release_reset();
  endtask

  task automatic start_run(output int base_cyc, output int base_idx);
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b0;
    base_cyc = cyc_free;
    base_idx = got_q.size();
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!halted && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_halted"}, halted, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_run(input string tag, input int base_cyc, input int base_idx);
    int n;
    ev_t g, e;
    model_run();
    check_eq({tag, "_r"}, r_out, m_r);
    check_eq({tag, "_depth"}, depth, m_depth);
    check_eq({tag, "_err"}, err, m_err);
    if (m_err != 0) check_eq({tag, "_pc"}, imem_addr, m_pc);
    check_eq({tag, "_ev_count"}, got_q.size() - base_idx, exp_q.size());
    n = got_q.size() - base_idx;
    if (exp_q.size() < n) n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      g = got_q[base_idx + i];
      e = exp_q[i];
      check_eq({tag, "_ev_cyc"}, g.cyc - base_cyc, e.cyc);
      check_eq({tag, "_ev_op"}, g.op, e.op);
      check_eq({tag, "_ev_data"}, g.data, e.data);
    end
  endtask

  task automatic run_prog(input string tag);
    int bc, bi;
    do_reset();
    start_run(bc, bi);
    wait_halt(tag);
    check_run(tag, bc, bi);
  endtask

  initial begin
    int bc, bi, len, sel, tgt, n;
    clear_rom();

    // Basic push/pop round trip with fixed pulse cycles.
    clear_rom();
    rom[0] = ins(1, 5); rom[1] = ins(2, 0); rom[2] = ins(1, 9);
    rom[3] = ins(3, 0); rom[4] = ins(15, 0);
    do_reset();
    start_run(bc, bi);
    wait_halt("t1");
    check_run("t1", bc, bi);
    check_eq("t1_push_cyc", got_q[bi].cyc - bc, 6);
    check_eq("t1_push_val", got_q[bi].data, 5);
    check_eq("t1_pop_cyc", got_q[bi + 1].cyc - bc, 12);
    check_eq("t1_r_final", r_out, 5);

    // Overflow on the 13th push.
    clear_rom();
    for (int a = 0; a < 13; a++) rom[a] = ins(2, 0);
    do_reset();
    start_run(bc, bi);
    wait_halt("t2");
    check_run("t2", bc, bi);
    check_eq("t2_pulses", got_q.size() - bi, 12);
    check_eq("t2_err", err, 1);

    // Underflow on the first instruction.
    clear_rom();
    rom[0] = ins(3, 0);
    run_prog("t3");
    check_eq("t3_err", err, 2);

    // ADD wraps to 1, JZ falls through, then an illegal opcode traps.
    clear_rom();
    rom[0] = ins(1, 14'h3FFF); rom[1] = ins(4, 2); rom[2] = ins(6, 14'h20);
    rom[3] = ins(9, 0); rom[14'h20] = ins(9, 0);
    run_prog("t4a");
    check_eq("t4a_pc", imem_addr, 3);

    // JZ taken with R==0.
    clear_rom();
    rom[0] = ins(1, 0); rom[1] = ins(6, 14'h20); rom[14'h20] = ins(9, 0);
    run_prog("t4b");
    check_eq("t4b_pc", imem_addr, 8'h20);

    // PC wraps from 0xFF back to 0.
    clear_rom();
    rom[0] = ins(6, 14'h10); rom[1] = ins(9, 0);
    rom[16] = ins(1, 1); rom[17] = ins(5, 14'hFF); rom[255] = ins(0, 0);
    run_prog("t5");
    check_eq("t5_pc", imem_addr, 1);

    // Asynchronous reset during the POP execute cycle.
    clear_rom();
    rom[0] = ins(1, 7); rom[1] = ins(2, 0); rom[2] = ins(3, 0);
    do_reset();
    start_run(bc, bi);
    n = 0;
    while (stk_opcode != 4'h3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_pop_seen", stk_opcode, 3);
    assert_reset();
    release_reset();
    check_eq("t6_stack_cleared", sp, 0);
    start_run(bc, bi);
    wait_halt("t6b");
    check_run("t6b", bc, bi);

    // Random forward-only programs.
    for (int t = 0; t < 25; t++) begin
      clear_rom();
      len = $urandom_range(8, 24);
      for (int i = 0; i < len; i++) begin
        sel = $urandom_range(0, 99);
        tgt = i + 1 + $urandom_range(0, 4);
        if (tgt > len) tgt = len;
        tgt = tgt + ($urandom_range(0, 63) << 8);
        if (sel < 10)      rom[i] = ins(0, $urandom_range(0, 16383));
        else if (sel < 25) rom[i] = ins(1, $urandom_range(0, 16383));
        else if (sel < 45) rom[i] = ins(2, 0);
        else if (sel < 60) rom[i] = ins(3, 0);
        else if (sel < 75) rom[i] = ins(4, $urandom_range(0, 16383));
        else if (sel < 83) rom[i] = ins(6, tgt);
        else if (sel < 90) rom[i] = ins(5, tgt);
        else if (sel < 95) rom[i] = ins($urandom_range(7, 14), 0);
        else               rom[i] = ins(15, 0);
      end
      run_prog("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
